bcd_wrap_counter: RTL
=====================

Name: bcd_wrap_counter

Overview:
- Parametrised two-digit BCD up/down counter with a configurable range [MIN_VALUE, MAX_VALUE], a run-time maximum override, synchronous load with validation, and separate carry and borrow pulses.
- Replaces the fixed 0-9/0-5 digit chains in the clock. One instance per time or date field: seconds, minutes, hours 0-23, day 1-31, month 1-12, year 0-99.
- Cascade by driving the next stage's en from carry_o | borrow_o.

Parameters:
- MIN_VALUE, 0, lowest count value (decimal, 0..98).
- MAX_VALUE, 59, static highest count value (decimal, MIN_VALUE+1..99).
- USE_DYN_MAX, 0, 1 = the max_ten/max_unit inputs define the highest value; 0 = the inputs are ignored.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable, one step per cycle while high.
- up  input  1  count-up request.
- down  input  1  count-down request.
- load  input  1  synchronous load strobe.
- load_ten  input  4  BCD tens digit to load.
- load_unit  input  4  BCD units digit to load.
- max_ten  input  4  run-time max tens digit (used only when USE_DYN_MAX=1).
- max_unit  input  4  run-time max units digit.
- cnt_ten  output  4  current tens digit, BCD.
- cnt_unit  output  4  current units digit, BCD.
- carry_o  output  1  one-cycle pulse on up-wrap.
- borrow_o  output  1  one-cycle pulse on down-wrap.
- load_err_o  output  1  one-cycle pulse when a load is rejected.
- at_max  output  1  count >= effective max (combinational from the registers).
- at_min  output  1  count == MIN_VALUE (combinational from the registers).

Behaviour:
- Reset (async assert, sync release): count = MIN_VALUE in BCD. carry_o, borrow_o and load_err_o are 0.
- Effective max (EMAX):
  - USE_DYN_MAX=0: EMAX = MAX_VALUE.
  - USE_DYN_MAX=1: EMAX = max_ten*10 + max_unit, sampled each cycle.
  - The dynamic value is invalid if either digit is >9, or the value is < MIN_VALUE+1. An invalid dynamic value falls back to MAX_VALUE.
- Step condition: step_up = en & up & ~down; step_dn = en & down & ~up. up=down=1 or en=0 holds the count.
- Priority per cycle: load > step > hold.
- Load:
  - Accepted if both digits are <=9 and MIN_VALUE <= value <= EMAX. The count then takes the value at the next edge.
  - Otherwise the count is unchanged and load_err_o pulses for 1 cycle.
  - A load suppresses any step in the same cycle; no carry or borrow is generated.
- Up step:
  - count < EMAX: increment in BCD. Units 9->0 with tens+1.
  - count >= EMAX: count = MIN_VALUE, and carry_o = 1 in the same cycle the MIN_VALUE appears.
  - This includes a count left above a newly lowered dynamic max.
- Down step:
  - count > MIN_VALUE and count <= EMAX: decrement in BCD. Units 0->9 with tens-1.
  - count == MIN_VALUE: count = EMAX, and borrow_o = 1.
  - count > EMAX (max lowered): count = EMAX with no borrow.
- Timing:
  - Count, carry_o, borrow_o and load_err_o are all registered. Latency is 1 clock from the enabling edge.
  - Pulses are high for exactly one cycle, unless a wrap recurs on the next step.
- Invariant: the count is never a non-BCD digit. If the dynamic max is lowered, the count may sit above EMAX until the next step; at_max is 1 in that case.
- Cascade: carry_o and borrow_o are mutually exclusive. carry_o | borrow_o fed to the next stage's en, with the same up/down, gives lossless multi-field chains.
- Width: all arithmetic is per-digit BCD; no binary intermediate wider than 7 bits.

Test Plan:
- Reset with MIN=0, MAX=59 -> count 00. Assert en and up for 60 cycles -> 59 reached after 59 steps. Step 60 gives 00 with carry_o high for exactly that cycle.
- MIN=1, MAX=12, count 01: step_dn -> count 12, borrow_o=1. Next step_dn -> 11, borrow_o=0.
- USE_DYN_MAX=1, MIN=1, max=31, count 30:
  - Change max to 28 -> count holds 30 and at_max=1.
  - step_up -> 01 with carry_o.
  - Repeat from 30: step_dn -> 28, no borrow.
- Load 0x5A with MAX=59 -> rejected: count unchanged, load_err_o=1 for 1 cycle.
- Load 0x60 with MAX=59 -> rejected.
- Load 0x45 in the same cycle as step_up -> count 45, no carry.
- en=1 with up=down=1 -> count holds and no pulses.
- Assert rst mid-count at 37 -> count 00 immediately, without waiting for a clock edge. Pulses are cleared; counting resumes on the first edge after release.

Source files
------------

// File: rtl/bcd_wrap_counter.sv
// rtl/bcd_wrap_counter.sv - two-digit BCD up/down counter with configurable range and wrap pulses
module bcd_wrap_counter #(
  parameter int MIN_VALUE   = 0,
  parameter int MAX_VALUE   = 59,
  parameter bit USE_DYN_MAX = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       down,
  input  logic       load,
  input  logic [3:0] load_ten,
  input  logic [3:0] load_unit,
  input  logic [3:0] max_ten,
  input  logic [3:0] max_unit,
  output logic [3:0] cnt_ten,
  output logic [3:0] cnt_unit,
  output logic       carry_o,
  output logic       borrow_o,
  output logic       load_err_o,
  output logic       at_max,
  output logic       at_min
);

  // Packed BCD {tens,units} orders the same as the decimal value when both digits are valid,
  // so all range checks are plain 8-bit compares on the packed digits.
  localparam logic [7:0] MIN_BCD   = {4'(MIN_VALUE / 10), 4'(MIN_VALUE % 10)};
  localparam logic [7:0] MINP1_BCD = {4'((MIN_VALUE + 1) / 10), 4'((MIN_VALUE + 1) % 10)};
  localparam logic [7:0] MAX_BCD   = {4'(MAX_VALUE / 10), 4'(MAX_VALUE % 10)};

  logic [7:0] cnt_q, cnt_nx;
  logic       carry_nx, borrow_nx, load_err_nx;
  logic [7:0] dyn_max, emax, load_val, cnt_inc, cnt_dec;
  logic       dyn_ok, load_ok, step_up, step_dn;

  assign dyn_max  = {max_ten, max_unit};
  assign dyn_ok   = (max_ten <= 4'd9) && (max_unit <= 4'd9) && (dyn_max >= MINP1_BCD);
  assign emax     = (USE_DYN_MAX && dyn_ok) ? dyn_max : MAX_BCD;

  assign load_val = {load_ten, load_unit};
  assign load_ok  = (load_ten <= 4'd9) && (load_unit <= 4'd9) &&
                    (load_val >= MIN_BCD) && (load_val <= emax);

  assign step_up  = en & up & ~down;
  assign step_dn  = en & down & ~up;

  assign cnt_inc  = (cnt_q[3:0] == 4'd9) ? {cnt_q[7:4] + 4'd1, 4'd0}
                                         : {cnt_q[7:4], cnt_q[3:0] + 4'd1};
  assign cnt_dec  = (cnt_q[3:0] == 4'd0) ? {cnt_q[7:4] - 4'd1, 4'd9}
                                         : {cnt_q[7:4], cnt_q[3:0] - 4'd1};

  always_comb begin
    cnt_nx      = cnt_q;
    carry_nx    = 1'b0;
    borrow_nx   = 1'b0;
    load_err_nx = 1'b0;
    if (load) begin
      if (load_ok) cnt_nx = load_val;
      else         load_err_nx = 1'b1;
    end else if (step_up) begin
      // A count stranded above a lowered max also wraps here.
      if (cnt_q >= emax) begin
        cnt_nx   = MIN_BCD;
        carry_nx = 1'b1;
      end else begin
        cnt_nx = cnt_inc;
      end
    end else if (step_dn) begin
      if (cnt_q == MIN_BCD) begin
        cnt_nx    = emax;
        borrow_nx = 1'b1;
      end else if (cnt_q > emax) begin
        cnt_nx = emax;
      end else begin
        cnt_nx = cnt_dec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= MIN_BCD;
      carry_o    <= 1'b0;
      borrow_o   <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      cnt_q      <= cnt_nx;
      carry_o    <= carry_nx;
      borrow_o   <= borrow_nx;
      load_err_o <= load_err_nx;
    end
  end

  assign cnt_ten  = cnt_q[7:4];
  assign cnt_unit = cnt_q[3:0];
  assign at_max   = (cnt_q >= emax);
  assign at_min   = (cnt_q == MIN_BCD);

endmodule
